// File: rtl/fir_stream_ctrl.sv
// Streaming front-end for a FIR engine: buffers upstream samples, issues one frame plus
// optional zero flush to the engine, and strobes captured results. Macro: FIR_FLUSH_EN.
module fir_stream_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int FLUSH_LEN  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] frame_len,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        fir_data_valid,
    output logic [15:0] fir_data,
    input  logic        fir_valid,
    input  logic [15:0] fir_d,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FLUSH_LEN < 1 || FLUSH_LEN > 64) begin : g_bad_cfg
        $error("fir_stream_ctrl: FIFO_DEPTH must be a power of two >= 2 and FLUSH_LEN 1..64");
    end

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [15:0] mem [FIFO_DEPTH];
    logic [11:0] len_r, acc_cnt, iss_cnt;
    logic        full, empty, push, pop, start_ok, last_run_issue, final_issue;
    logic        out_valid_r, out_last_r;

    // The extra wrap bit separates full from empty when the index bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign start_ok       = (state == IDLE) && start;
    assign in_ready       = (state == RUN) && !full && (acc_cnt < len_r);
    assign push           = in_valid && in_ready;
    assign pop            = (state == RUN) && !empty;
    assign last_run_issue = pop && (iss_cnt == len_r - 12'd1);

`ifdef FIR_FLUSH_EN
    localparam logic [5:0] FLUSH_LAST = 6'(FLUSH_LEN - 1);

    logic [5:0] flush_cnt;
    logic       flush_last;

    assign flush_last  = (flush_cnt == FLUSH_LAST);
    assign final_issue = (state == FLUSH) && flush_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + 6'd1;
        end else begin
            flush_cnt <= '0;
        end
    end
`else
    assign final_issue = last_run_issue;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
`ifdef FIR_FLUSH_EN
            RUN:   if (last_run_issue) state_nxt = FLUSH;
            FLUSH: if (flush_last) state_nxt = DRAIN;
`else
            RUN:   if (last_run_issue) state_nxt = DRAIN;
`endif
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue mux: FIFO head in RUN, zeros while flushing, otherwise quiet.
    always_comb begin
        fir_data_valid = 1'b0;
        fir_data       = '0;
        if (pop) begin
            fir_data_valid = 1'b1;
            fir_data       = mem[rd_ptr[AW-1:0]];
        end
`ifdef FIR_FLUSH_EN
        if (state == FLUSH) begin
            fir_data_valid = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len_r   <= '0;
            acc_cnt <= '0;
            iss_cnt <= '0;
        end else if (start_ok) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            acc_cnt <= '0;
            iss_cnt <= '0;
            len_r   <= (frame_len == 12'd0) ? 12'd1 : frame_len;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 12'd1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                iss_cnt <= iss_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // The engine presents its result the cycle after an issue, so the strobe is
    // delayed one cycle and out_data follows fir_d during that window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= fir_data_valid && fir_valid;
            out_last_r  <= fir_data_valid && fir_valid && final_issue;
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_valid_r ? fir_d : 16'd0;
    assign busy      = (state != IDLE);
    assign done      = (state == DRAIN);

endmodule
